// File: rtl/lift_dma.sv
// lift_dma: bulk transfer engine between a 60-bit coefficient stream and the 240-bit lift port of memory2048.
// Optional feature: define LIFT_DMA_CHECKSUM_EN to add a running XOR checksum output.
module lift_dma #(
   parameter int ADDR_W = 9,
   parameter int COEF_W = 60,
   parameter int LANES  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     dir,
   input  logic [ADDR_W-1:0]        num_words,
   output logic                     busy,
   output logic                     done,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [COEF_W-1:0]        in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [COEF_W-1:0]        out_data,
   output logic                     lift_interrupt,
   output logic [ADDR_W-1:0]        lift_address,
   output logic                     lift_we,
   output logic [LANES*COEF_W-1:0]  lift_wr_data,
   input  logic [LANES*COEF_W-1:0]  lift_rd_data
`ifdef LIFT_DMA_CHECKSUM_EN
   ,
   output logic [COEF_W-1:0]        checksum
`endif
);

   localparam int WORD_W = LANES * COEF_W;
   localparam int LANE_W = $clog2(LANES);
   localparam int CNT_W  = ADDR_W + 1;
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
   localparam logic [CNT_W-1:0]  MAX_WORDS = CNT_W'(1) << ADDR_W;

   typedef enum logic [2:0] {
      IDLE, L_GATHER, L_WRITE, U_ADDR, U_WAIT, U_EMIT, DONE
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [LANE_W-1:0]  lane_q, lane_d;
   logic [WORD_W-1:0]  pack_q, pack_d;
   logic [WORD_W-1:0]  shift_q, shift_d;
   logic               start_acc;
   logic               in_fire;
   logic               out_fire;
   logic               last_word;

   assign start_acc = (state_q == IDLE) && start;
   assign in_fire   = in_ready && in_valid;
   assign out_fire  = out_valid && out_ready;
   assign last_word = (cnt_q == CNT_W'(1));

   // NOTE: every signal written here gets its default first, so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      lane_d    = lane_q;
      pack_d    = pack_q;
      shift_d   = shift_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      lift_we   = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               cnt_d   = (num_words == '0) ? MAX_WORDS : CNT_W'(num_words);
               addr_d  = '0;
               lane_d  = '0;
               state_d = dir ? U_ADDR : L_GATHER;
            end
         end

         L_GATHER: begin
            in_ready = 1'b1;
            if (in_valid) begin
               pack_d[int'(lane_q)*COEF_W +: COEF_W] = in_data;
               lane_d = lane_q + 1'b1;
               if (lane_q == LAST_LANE) state_d = L_WRITE;
            end
         end

         // One write strobe per packed word; the address steps once the strobe has been seen.
         L_WRITE: begin
            lift_we = 1'b1;
            addr_d  = addr_q + 1'b1;
            cnt_d   = cnt_q - 1'b1;
            state_d = last_word ? DONE : L_GATHER;
         end

         U_ADDR: state_d = U_WAIT;

         U_WAIT: begin
            shift_d = lift_rd_data;
            state_d = U_EMIT;
         end

         // Lane 0 always sits at the bottom of the shift buffer, so out_data needs no mux.
         U_EMIT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               shift_d = shift_q >> COEF_W;
               lane_d  = lane_q + 1'b1;
               if (lane_q == LAST_LANE) begin
                  cnt_d   = cnt_q - 1'b1;
                  addr_d  = addr_q + 1'b1;
                  state_d = last_word ? DONE : U_ADDR;
               end
            end
         end

         DONE: state_d = IDLE;

         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         lane_q  <= '0;
         pack_q  <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         lane_q  <= lane_d;
         pack_q  <= pack_d;
         shift_q <= shift_d;
      end
   end

   assign busy           = (state_q != IDLE) && (state_q != DONE);
   assign lift_interrupt = busy;
   assign done           = (state_q == DONE);
   assign lift_address   = addr_q;
   assign lift_wr_data   = pack_q;
   assign out_data       = shift_q[COEF_W-1:0];

`ifdef LIFT_DMA_CHECKSUM_EN
   logic [COEF_W-1:0] chk_q, chk_d;

   always_comb begin
      chk_d = chk_q;
      if (start_acc)     chk_d = '0;
      else if (in_fire)  chk_d = chk_q ^ in_data;
      else if (out_fire) chk_d = chk_q ^ out_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) chk_q <= '0;
      else     chk_q <= chk_d;
   end

   assign checksum = chk_q;
`else
   // Handshake strobes only feed the checksum; keep them referenced in the plain build.
   logic unused_strobes;
   assign unused_strobes = start_acc ^ in_fire ^ out_fire;
`endif

endmodule

// File: tb/tb_lift_dma.sv
// Scoreboard bench for lift_dma: stimulus pushes expected lift writes and stream beats, a negedge monitor checks them.
module tb_lift_dma;
   localparam int ADDR_W = 9;
   localparam int COEF_W = 60;
   localparam int WORD_W = 240;

   logic                clk = 1'b0;
   logic                rst;
   logic                start;
   logic                dir;
   logic [ADDR_W-1:0]   num_words;
   logic                busy;
   logic                done;
   logic                in_valid;
   logic                in_ready;
   logic [COEF_W-1:0]   in_data;
   logic                out_valid;
   logic                out_ready;
   logic [COEF_W-1:0]   out_data;
   logic                lift_interrupt;
   logic [ADDR_W-1:0]   lift_address;
   logic                lift_we;
   logic [WORD_W-1:0]   lift_wr_data;
   logic [WORD_W-1:0]   lift_rd_data = '0;
`ifdef LIFT_DMA_CHECKSUM_EN
   logic [COEF_W-1:0]   checksum;
`endif

   lift_dma dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .dir            (dir),
      .num_words      (num_words),
      .busy           (busy),
      .done           (done),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .lift_interrupt (lift_interrupt),
      .lift_address   (lift_address),
      .lift_we        (lift_we),
      .lift_wr_data   (lift_wr_data),
      .lift_rd_data   (lift_rd_data)
`ifdef LIFT_DMA_CHECKSUM_EN
      ,
      .checksum       (checksum)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [WORD_W-1:0] pack4(input int c0, input int c1, input int c2, input int c3);
      logic [WORD_W-1:0] w;
      w = '0;
      w[0*COEF_W +: COEF_W] = COEF_W'(c0);
      w[1*COEF_W +: COEF_W] = COEF_W'(c1);
      w[2*COEF_W +: COEF_W] = COEF_W'(c2);
      w[3*COEF_W +: COEF_W] = COEF_W'(c3);
      return w;
   endfunction

   function automatic logic [WORD_W-1:0] pattern_word(input logic [ADDR_W-1:0] a);
      int base;
      base = 4 * int'(a);
      return pack4(base, base + 1, base + 2, base + 3);
   endfunction

   // memory2048 lift-port model: synchronous write, read data one cycle after the address.
   logic [WORD_W-1:0] mem [0:511];
   logic              pattern_mode = 1'b0;
   always @(posedge clk) begin
      if (lift_we) mem[lift_address] <= lift_wr_data;
      lift_rd_data <= pattern_mode ? pattern_word(lift_address) : mem[lift_address];
   end

   // out_ready driver: always high, or high for one cycle after a random 0..5 cycle gap.
   logic ready_rand = 1'b0;
   int   gap_left   = 0;
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (!ready_rand) begin
            out_ready = 1'b1;
         end else if (gap_left > 0) begin
            out_ready = 1'b0;
            gap_left--;
         end else begin
            out_ready = 1'b1;
            gap_left  = $urandom_range(0, 5);
         end
      end
   end

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [WORD_W-1:0] data;
   } wr_t;

   wr_t               exp_wr [$];
   logic [COEF_W-1:0] exp_out [$];
   int                done_cnt = 0;
   logic              stall_pend = 1'b0;
   logic [COEF_W-1:0] stall_data = '0;
   wr_t               mon_wr;
   logic [COEF_W-1:0] mon_out;

   // Monitor: compares every lift write and every stream handshake against the queues.
   always @(negedge clk) begin
      if (rst) begin
         stall_pend = 1'b0;
      end else begin
         if (done) done_cnt++;
         if (lift_we) begin
            if (exp_wr.size() == 0) begin
               check("unexpected_lift_we", lift_we, 1'b0);
            end else begin
               mon_wr = exp_wr.pop_front();
               check("lift_address", lift_address, mon_wr.addr);
               check("lift_wr_data", lift_wr_data, mon_wr.data);
            end
         end
         if (out_valid && stall_pend) check("out_data_hold", out_data, stall_data);
         stall_pend = out_valid && !out_ready;
         stall_data = out_data;
         if (out_valid && out_ready) begin
            if (exp_out.size() == 0) begin
               check("unexpected_out_beat", out_valid, 1'b0);
            end else begin
               mon_out = exp_out.pop_front();
               check("out_data", out_data, mon_out);
            end
         end
      end
   end

   // All driver tasks enter and leave 1 time unit after a rising edge.
   task automatic pulse_start(input logic d, input logic [ADDR_W-1:0] n);
      start     = 1'b1;
      dir       = d;
      num_words = n;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic send_beat(input int value, input int gap);
      logic hs;
      hs = 1'b0;
      in_valid = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      in_valid = 1'b1;
      in_data  = COEF_W'(value);
      for (int t = 0; t < 200 && !hs; t++) begin
         @(negedge clk);
         hs = in_ready;
         @(posedge clk);
         #1;
      end
      if (!hs) check("in_ready_timeout", hs, 1'b1);
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      logic seen;
      seen = 1'b0;
      for (int t = 0; t < budget && !seen; t++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      check("done_seen", seen, 1'b1);
      if (seen) begin
         check("busy_low_at_done", busy, 1'b0);
         check("irq_low_at_done", lift_interrupt, 1'b0);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int d0;
      rst       = 1'b1;
      start     = 1'b0;
      dir       = 1'b0;
      num_words = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      idle_cycles(3);

      // Reset state
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_irq", lift_interrupt, 1'b0);
      check("rst_lift_we", lift_we, 1'b0);
      check("rst_lift_address", lift_address, '0);
      check("rst_lift_wr_data", lift_wr_data, '0);
      check("rst_out_data", out_data, '0);
`ifdef LIFT_DMA_CHECKSUM_EN
      check("rst_checksum", checksum, '0);
`endif
      rst = 1'b0;
      idle_cycles(2);

      // Load 2 words; a start pulse between the words must be ignored.
      exp_wr.push_back('{addr: 9'd0, data: pack4(1, 2, 3, 4)});
      exp_wr.push_back('{addr: 9'd1, data: pack4(5, 6, 7, 8)});
      d0 = done_cnt;
      pulse_start(1'b0, 9'd2);
      check("load_busy", busy, 1'b1);
      check("load_irq", lift_interrupt, 1'b1);
      for (int i = 1; i <= 4; i++) send_beat(i, 0);
      pulse_start(1'b1, 9'd5);
      for (int i = 5; i <= 8; i++) send_beat(i, 0);
      wait_done(100);
      check("load2_addr_final", lift_address, 9'd2);
      check("load2_done_once", done_cnt, d0 + 1);
      check("load2_writes_consumed", exp_wr.size(), 0);
`ifdef LIFT_DMA_CHECKSUM_EN
      check("load2_checksum", checksum, 60'h8);
`endif
      idle_cycles(2);

      // Unload all 512 words from the pattern memory.
      pattern_mode = 1'b1;
      for (int i = 0; i < 2048; i++) exp_out.push_back(COEF_W'(i));
      d0 = done_cnt;
      pulse_start(1'b1, 9'd0);
      check("unload_lat_c1", out_valid, 1'b0);
      idle_cycles(1);
      check("unload_lat_c2", out_valid, 1'b0);
      idle_cycles(1);
      check("unload_lat_c3", out_valid, 1'b1);
      wait_done(4000);
      check("unload512_addr_wrap", lift_address, 9'd0);
      check("unload512_beats_consumed", exp_out.size(), 0);
      idle_cycles(10);
      check("unload512_done_once", done_cnt, d0 + 1);
      check("unload512_addr_held", lift_address, 9'd0);
      pattern_mode = 1'b0;

      // Backpressure: 3-word load with input gaps, then unload with out_ready gaps.
      for (int w = 0; w < 3; w++)
         exp_wr.push_back('{addr: ADDR_W'(w),
                            data: pack4(100 + 4*w, 101 + 4*w, 102 + 4*w, 103 + 4*w)});
      pulse_start(1'b0, 9'd3);
      for (int i = 0; i < 12; i++) send_beat(100 + i, $urandom_range(0, 5));
      wait_done(200);
      check("bp_load_addr", lift_address, 9'd3);
      check("bp_writes_consumed", exp_wr.size(), 0);
      for (int i = 0; i < 12; i++) exp_out.push_back(COEF_W'(100 + i));
      ready_rand = 1'b1;
      pulse_start(1'b1, 9'd3);
      wait_done(400);
      ready_rand = 1'b0;
      check("bp_unload_addr", lift_address, 9'd3);
      check("bp_beats_consumed", exp_out.size(), 0);
      idle_cycles(2);

      // Reset in the middle of word 0 after two beats; no write may follow.
      pulse_start(1'b0, 9'd1);
      send_beat(11, 0);
      send_beat(12, 0);
      in_valid = 1'b1;
      in_data  = COEF_W'(13);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_irq", lift_interrupt, 1'b0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_in_ready", in_ready, 1'b0);
      check("midrst_wr_data", lift_wr_data, '0);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle_cycles(5);
      exp_wr.push_back('{addr: 9'd0, data: pack4(21, 22, 23, 24)});
      pulse_start(1'b0, 9'd1);
      for (int i = 21; i <= 24; i++) send_beat(i, 0);
      wait_done(100);
      check("postrst_addr", lift_address, 9'd1);
      check("postrst_writes_consumed", exp_wr.size(), 0);

`ifdef LIFT_DMA_CHECKSUM_EN
      // Checksum over one word {0xA, 0x5, 0xF, 0x0} in each direction.
      exp_wr.push_back('{addr: 9'd0, data: pack4(10, 5, 15, 0)});
      pulse_start(1'b0, 9'd1);
      send_beat(10, 0);
      send_beat(5, 0);
      send_beat(15, 0);
      send_beat(0, 0);
      wait_done(100);
      check("chk_load", checksum, '0);
      exp_out.push_back(COEF_W'(10));
      exp_out.push_back(COEF_W'(5));
      exp_out.push_back(COEF_W'(15));
      exp_out.push_back(COEF_W'(0));
      pulse_start(1'b1, 9'd1);
      idle_cycles(3);
      check("chk_mid_unload", checksum, 60'hA);
      wait_done(100);
      check("chk_unload", checksum, '0);
      check("chk_beats_consumed", exp_out.size(), 0);
`endif

      idle_cycles(3);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
